// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target bridge: FSM states and
// the command / fill byte values seen on the wire.
package spi_target_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RDUMMY,
        RDATA,
        IGNORE
    } state_t;

    localparam logic [7:0] CMD_READ     = 8'h80;
    localparam logic [7:0] CMD_WRITE    = 8'h00;
    localparam logic [7:0] OVERRUN_FILL = 8'hFF;

endpackage

// File: rtl/spi_target_bridge_if.sv
// Single-beat request/acknowledge bus between the SPI target and the CPU bus arbiter.
// Handshake: the master raises bus_req with we/addr/wdata stable and holds them until
// the cycle bus_ack is seen high; ack is a one-cycle strobe and is ignored while req is low.
interface spi_target_bridge_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic                  bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/spi_target_sync.sv
// Brings the SPI pins into the clk_i domain through 2-FF synchronizers and
// produces registered edge strobes (3 cycles pin-to-strobe) with MOSI aligned to them.
module spi_target_sync (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic sclk_i,
    input  logic cs_ni,
    input  logic mosi_i,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi,
    output logic cs_n_sync
);
    logic sclk_meta, sclk_sync, sclk_prev;
    logic cs_meta, cs_prev;
    logic mosi_meta, mosi_sync;

    // CS resets to the inactive (high) level so reset never fabricates a frame edge.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            cs_meta   <= 1'b1;
            cs_n_sync <= 1'b1;
            cs_prev   <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            mosi      <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
        end else begin
            sclk_meta <= sclk_i;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            cs_meta   <= cs_ni;
            cs_n_sync <= cs_meta;
            cs_prev   <= cs_n_sync;
            mosi_meta <= mosi_i;
            mosi_sync <= mosi_meta;
            mosi      <= mosi_sync;
            sclk_rise <= sclk_sync & ~sclk_prev;
            sclk_fall <= ~sclk_sync & sclk_prev;
            cs_fall   <= ~cs_n_sync & cs_prev;
            cs_rise   <= cs_n_sync & ~cs_prev;
        end
    end
endmodule

// File: rtl/spi_target_bridge.sv
// SPI mode-0 target that turns command/address/data frames into single-beat
// reads and writes on the system bus, with read prefetch and overrun flagging.
module spi_target_bridge
    import spi_target_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                spi_sclk_i,
    input  logic                spi_cs_ni,
    input  logic                spi_mosi_i,
    output logic                spi_miso_o,
    output logic                spi_miso_oe_o,
    spi_target_bridge_if.master bus,
    output logic                busy_o,
    output logic                err_o,
    output state_t              state_o
);
    localparam int ADDR_BYTES = ADDR_WIDTH / 8;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi, cs_n_sync;

    spi_target_sync u_sync (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .sclk_i    (spi_sclk_i),
        .cs_ni     (spi_cs_ni),
        .mosi_i    (spi_mosi_i),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .mosi      (mosi),
        .cs_n_sync (cs_n_sync)
    );

    state_t                state_q, state_d;
    logic [2:0]            bit_cnt;
    logic [3:0]            addr_cnt;
    logic                  is_read, rd_skip, err_q;
    logic [DATA_WIDTH-1:0] rx_q, tx_q, rd_buf, wdata_q;
    logic [ADDR_WIDTH-1:0] addr_q, req_addr;
    logic                  req_q, we_q;

    logic [DATA_WIDTH-1:0] rx_byte, rd_data_now;
    logic [ADDR_WIDTH-1:0] addr_next, addr_inc;
    logic                  byte_done, last_addr, req_busy;

    assign rx_byte   = {rx_q[DATA_WIDTH-2:0], mosi};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);
    assign last_addr = (addr_cnt == 4'(ADDR_BYTES - 1));
    assign addr_next = (addr_q << 8) | ADDR_WIDTH'(rx_byte);
    assign addr_inc  = addr_q + ADDR_WIDTH'(1);
    // A request acked this cycle frees the port, so it does not count as an overrun.
    assign req_busy  = req_q && !bus.bus_ack;
    assign rd_data_now = (req_q && bus.bus_ack && !we_q) ? bus.bus_rdata : rd_buf;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else if (cs_fall) begin
            state_d = CMD;
        end else begin
            case (state_q)
                CMD: if (byte_done) begin
                    if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) state_d = ADDR;
                    else                                             state_d = IGNORE;
                end
                ADDR:    if (byte_done && last_addr) state_d = is_read ? RDUMMY : WDATA;
                RDUMMY:  if (byte_done) state_d = RDATA;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            bit_cnt  <= '0;
            addr_cnt <= '0;
            is_read  <= 1'b0;
            rd_skip  <= 1'b0;
            err_q    <= 1'b0;
            rx_q     <= '0;
            tx_q     <= '0;
            rd_buf   <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            req_addr <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            if (req_q && bus.bus_ack) begin
                req_q <= 1'b0;
                if (!we_q) rd_buf <= bus.bus_rdata;
            end
            if (cs_fall) begin
                bit_cnt  <= '0;
                addr_cnt <= '0;
                is_read  <= 1'b0;
                rd_skip  <= 1'b0;
                err_q    <= 1'b0;
                rx_q     <= '0;
                tx_q     <= '0;
            end else if (cs_rise) begin
                bit_cnt <= '0;
                tx_q    <= '0;
            end else if (state_q != IDLE) begin
                if (sclk_rise) begin
                    rx_q    <= rx_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (byte_done && state_q == CMD) is_read <= (rx_byte == CMD_READ);
                    if (byte_done && state_q == ADDR) begin
                        addr_q   <= addr_next;
                        addr_cnt <= addr_cnt + 4'd1;
                        if (last_addr && is_read) begin
                            if (req_busy) begin
                                err_q   <= 1'b1;
                                rd_skip <= 1'b1;
                            end else begin
                                req_q    <= 1'b1;
                                we_q     <= 1'b0;
                                req_addr <= addr_next;
                            end
                        end
                    end
                    if (byte_done && state_q == WDATA) begin
                        addr_q <= addr_inc;
                        if (req_busy) begin
                            err_q <= 1'b1;
                        end else begin
                            req_q    <= 1'b1;
                            we_q     <= 1'b1;
                            req_addr <= addr_q;
                            wdata_q  <= rx_byte;
                        end
                    end
                    // Prefetch on the first bit of each read byte; the data is due at the next boundary.
                    if (bit_cnt == 3'd0 && state_q == RDATA) begin
                        addr_q <= addr_inc;
                        if (req_busy) begin
                            err_q   <= 1'b1;
                            rd_skip <= 1'b1;
                        end else begin
                            req_q    <= 1'b1;
                            we_q     <= 1'b0;
                            req_addr <= addr_inc;
                        end
                    end
                end
                if (sclk_fall) begin
                    if (bit_cnt != 3'd0) begin
                        tx_q <= {tx_q[DATA_WIDTH-2:0], 1'b0};
                    end else if (state_q == RDATA) begin
                        rd_skip <= 1'b0;
                        if (rd_skip || req_busy) begin
                            tx_q  <= OVERRUN_FILL;
                            err_q <= 1'b1;
                        end else begin
                            tx_q <= rd_data_now;
                        end
                    end else begin
                        tx_q <= '0;
                    end
                end
            end
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = req_addr;
    assign bus.bus_wdata = wdata_q;

    assign spi_miso_oe_o = ~cs_n_sync;
    assign spi_miso_o    = tx_q[DATA_WIDTH-1] & ~cs_n_sync;
    assign busy_o        = ~cs_n_sync | req_q;
    assign err_o         = err_q;
    assign state_o       = state_q;
endmodule
